// File: rtl/rv32i_types.sv
// Shared types and line-geometry constants for the instruction-side memory responder.
package rv32i_types;

  typedef enum logic [1:0] {IDLE, RESP, REQ, FILL} imem_state_t;

  localparam int IMEM_BEAT_W = 64;
  localparam int IMEM_BEATS  = 4;
  localparam int LINE_BYTES  = IMEM_BEAT_W * IMEM_BEATS / 8;
  localparam int OFFSET_W    = $clog2(LINE_BYTES);
  localparam int WORD_SEL_W  = OFFSET_W - 2;

  function automatic int line_offset_w(input int beat_w, input int beats);
    return $clog2(beat_w * beats / 8);
  endfunction

endpackage

// File: rtl/imem_line_buf.sv
// Single cacheline buffer: beat-wide write port, tag compare and 32-bit word read.
module imem_line_buf
  import rv32i_types::*;
#(
  parameter int BEAT_W = IMEM_BEAT_W,
  parameter int BEATS  = IMEM_BEATS,
  localparam int OFF_W = line_offset_w(BEAT_W, BEATS),
  localparam int TAG_W = 32 - OFF_W,
  localparam int SEL_W = OFF_W - 2,
  localparam int CNT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inval,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              fill_done,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [TAG_W-1:0]  cmp_tag,
  output logic              hit,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [31:0]       rd_word
);

  localparam int WORDS = BEATS * BEAT_W / 32;

  logic [BEATS-1:0][BEAT_W-1:0] data_q, data_d, line_view;
  logic [WORDS-1:0][31:0]       words;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic                         valid_q, valid_d;

  // The read view includes the beat being written so the last refill beat is visible immediately.
  always_comb begin
    line_view = data_q;
    if (wr_en) line_view[wr_idx] = wr_data;
    data_d  = line_view;
    tag_d   = fill_done ? fill_tag : tag_q;
    valid_d = valid_q;
    if (inval)     valid_d = 1'b0;
    if (fill_done) valid_d = 1'b1;
  end

  assign words   = line_view;
  assign rd_word = words[rd_sel];
  assign hit     = valid_q && (tag_q == cmp_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder with a one-line buffer and burst refill from backing memory.
// Optional hit/miss counters are enabled by defining IMEM_PERF_CNT_EN.
module imem_responder
  import rv32i_types::*;
#(
  parameter int BEAT_W = IMEM_BEAT_W,
  parameter int BEATS  = IMEM_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imem_addr,
  input  logic [3:0]        imem_rmask,
  output logic [31:0]       imem_rdata,
  output logic              imem_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W = line_offset_w(BEAT_W, BEATS);
  localparam int TAG_W = 32 - OFF_W;
  localparam int SEL_W = OFF_W - 2;
  localparam int CNT_W = $clog2(BEATS);

  imem_state_t      state_q, state_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_q, resp_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             req_present;
  logic             sampling;
  logic             buf_hit;
  logic             fill_beat;
  logic             last_beat;
  logic             inval;
  logic [SEL_W-1:0] rd_sel;
  logic [31:0]      rd_word;
  logic             unused_addr_bits;

  assign req_present = |imem_rmask;
  assign sampling    = (state_q == IDLE) || (state_q == RESP);
  assign fill_beat   = (state_q == FILL) && bmem_rvalid;
  assign last_beat   = fill_beat && (cnt_q == CNT_W'(BEATS - 1));
  assign inval       = (state_q == REQ) && bmem_ready;
  // During refill the word comes from the latched request, otherwise from the live fetch address.
  assign rd_sel      = (state_q == FILL) ? req_addr_q[OFF_W-1:2] : imem_addr[OFF_W-1:2];

  assign unused_addr_bits = ^{imem_addr[1:0], req_addr_q[1:0]};

  imem_line_buf #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .inval     (inval),
    .wr_en     (fill_beat),
    .wr_idx    (cnt_q),
    .wr_data   (bmem_rdata),
    .fill_done (last_beat),
    .fill_tag  (req_addr_q[31:OFF_W]),
    .cmp_tag   (imem_addr[31:OFF_W]),
    .hit       (buf_hit),
    .rd_sel    (rd_sel),
    .rd_word   (rd_word)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    resp_d     = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req_present) begin
          req_addr_d = imem_addr;
          if (buf_hit) begin
            state_d = RESP;
            resp_d  = 1'b1;
            rdata_d = rd_word;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bmem_rvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = RESP;
            resp_d  = 1'b1;
            rdata_d = rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign bmem_read  = (state_q == REQ);
  assign bmem_addr  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Counters saturate rather than wrap.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (sampling && req_present) begin
      if (buf_hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed fetch/refill scenarios plus randomized traffic.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  imem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
`ifdef IMEM_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, maintained by the stimulus process.
  logic        exp_resp = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_read = 1'b0;
  logic [31:0] exp_addr = '0;
  logic        chk_en = 1'b0;

  // Behavioural model of the buffered line.
  logic        m_valid = 1'b0;
  logic [26:0] m_tag = '0;
  logic [31:0] m_hits = '0;
  logic [31:0] m_misses = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h6000_0000) return 32'h0000_0093;
    if (a == 32'h6000_0004) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("imem_resp", {31'b0, imem_resp}, {31'b0, exp_resp});
      if (exp_resp) chk("imem_rdata", imem_rdata, exp_rdata);
      chk("bmem_read", {31'b0, bmem_read}, {31'b0, exp_read});
      if (exp_read) chk("bmem_addr", bmem_addr, exp_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_resp = 1'b0;
  endtask

  task automatic idle(input int n);
    imem_rmask = 4'h0;
    for (int i = 0; i < n; i++) begin
      bmem_ready  = 1'($urandom_range(0, 1));
      bmem_rvalid = 1'($urandom_range(0, 1));
      bmem_rdata  = {$urandom, $urandom};
      tick();
    end
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input int dly, input bit chg);
    logic [31:0] line;
    bit          hit;
    int          gap;
    line        = {a[31:5], 5'b0};
    imem_addr   = a;
    imem_rmask  = 4'($urandom_range(1, 15));
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    hit = m_valid && (m_tag == a[31:5]);
    tick();
    if (hit) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else begin
      if (m_misses != 32'hFFFF_FFFF) m_misses++;
      exp_read = 1'b1;
      exp_addr = line;
      for (int i = 0; i < dly; i++) begin
        bmem_rvalid = 1'($urandom_range(0, 1));
        bmem_rdata  = {$urandom, $urandom};
        tick();
      end
      bmem_rvalid = 1'b0;
      bmem_ready  = 1'b1;
      tick();
      bmem_ready = 1'b0;
      exp_read   = 1'b0;
      m_valid    = 1'b0;
      for (int b = 0; b < 4; b++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          bmem_ready = 1'($urandom_range(0, 1));
          tick();
        end
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_rdata  = {mem_word(line + 32'(8 * b + 4)), mem_word(line + 32'(8 * b))};
        tick();
        bmem_rvalid = 1'b0;
        if (chg && b == 0) imem_addr = 32'h6000_1000;
      end
      m_valid = 1'b1;
      m_tag   = a[31:5];
    end
    exp_resp   = 1'b1;
    exp_rdata  = mem_word({a[31:2], 2'b00});
    imem_rmask = 4'h0;
  endtask

  logic [31:0] lines [5] = '{32'h6000_0000, 32'h6000_0020, 32'h6000_0040, 32'h6000_0060, 32'hFFFF_FFE0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    imem_addr   = '0;
    imem_rmask  = '0;
    bmem_ready  = 1'b0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_resp", {31'b0, imem_resp}, 32'd0);
    chk("reset_rdata", imem_rdata, 32'd0);
    chk("reset_read", {31'b0, bmem_read}, 32'd0);
    chk("reset_baddr", bmem_addr, 32'd0);
    chk_en = 1'b1;
    idle(2);

    do_req(32'h6000_0000, 2, 1'b0);
    chk("first_word", imem_rdata, 32'h0000_0093);
    idle(1);

    do_req(32'h6000_0004, 0, 1'b0);
    chk("b2b_word1", imem_rdata, 32'h0000_0013);
    do_req(32'h6000_0008, 0, 1'b0);
    do_req(32'h6000_001C, 0, 1'b0);
    chk("b2b_word7", imem_rdata, 32'h3A5A_001C);
    idle(1);

    do_req(32'h6000_0020, 1, 1'b0);
    idle(1);
    do_req(32'h6000_0000, 0, 1'b0);
    idle(1);
    do_req(32'h6000_0044, 1, 1'b1);
    chk("fill_addr_change", imem_rdata, 32'h3A5A_0044);
    idle(1);

    // Reset in the middle of a refill, followed by stray beats.
    imem_addr  = 32'h6000_0080;
    imem_rmask = 4'hF;
    if (m_misses != 32'hFFFF_FFFF) m_misses++;
    tick();
    exp_read   = 1'b1;
    exp_addr   = 32'h6000_0080;
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    exp_read   = 1'b0;
    m_valid    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = {mem_word(32'h6000_0084 + 32'(8 * b)), mem_word(32'h6000_0080 + 32'(8 * b))};
      tick();
    end
    bmem_rvalid = 1'b0;
    imem_rmask  = 4'h0;
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    m_hits   = '0;
    m_misses = '0;
    chk("midfill_rst_resp", {31'b0, imem_resp}, 32'd0);
    chk("midfill_rst_rdata", imem_rdata, 32'd0);
    chk("midfill_rst_baddr", bmem_addr, 32'd0);
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = {$urandom, $urandom};
      tick();
    end
    bmem_rvalid = 1'b0;
    do_req(32'h6000_0000, 0, 1'b0);
    chk("after_rst_word", imem_rdata, 32'h0000_0093);
    idle(1);

    do_req(32'hFFFF_FFFC, 1, 1'b0);
    chk("top_word", imem_rdata, 32'hA5A5_FFFC);
    idle(1);

    for (int it = 0; it < 300; it++) begin
      logic [31:0] a;
      a = lines[$urandom_range(0, 4)] | (32'($urandom_range(0, 7)) << 2);
      do_req(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

`ifdef IMEM_PERF_CNT_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    force dut.hit_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_count_q;
    m_hits = 32'hFFFF_FFFE;
    do_req({m_tag, 5'b0}, 0, 1'b0);
    idle(1);
    chk("hit_count_sat1", hit_count, 32'hFFFF_FFFF);
    do_req({m_tag, 5'b0} | 32'h4, 0, 1'b0);
    idle(1);
    chk("hit_count_sat2", hit_count, 32'hFFFF_FFFF);
    force dut.miss_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_count_q;
    do_req({m_tag, 5'b0} ^ 32'h0000_0100, 0, 1'b0);
    idle(1);
    chk("miss_count_sat", miss_count, 32'hFFFF_FFFF);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
